lut_reload_ctrl: RTL and testbench
==================================

// Module: lut_reload_ctrl
// PURPOSE
// - Run-time reload controller for the 256x8 pixel LUT (binarization threshold table) in the HDMI rx->tx path.
// - Accepts a threshold request and waits for vertical blanking.
// - Rewrites all 256 LUT entries while rx_de is low, then acknowledges the requester.
// - Frames never see a half-written table: a write is aborted if active video starts.
// PARAMETERS
// - VS_POL     1  active level of rx_vsync (1 = high-active blanking pulse)
// - MAX_RETRY  3  aborted reload attempts allowed before giving up with cfg_err (1..15)
// PORTS
// - rx_pclk     in   1  pixel clock; sole clock
// - rst         in   1  asynchronous, active-high reset
// - rx_vsync    in   1  vertical sync from hdmi_in
// - rx_de       in   1  data enable from hdmi_in
// - cfg_req     in   1  reload request (level; held until cfg_ack)
// - cfg_thr     in   8  threshold; sampled when the request is accepted
// - cfg_ack     out  1  one-cycle pulse: reload finished (see cfg_err)
// - cfg_err     out  1  valid with cfg_ack: 1 = MAX_RETRY exceeded, LUT content undefined
// - busy        out  1  high from request acceptance until the cycle after cfg_ack
// - lut_we      out  1  LUT write enable
// - lut_addr    out  8  LUT write address
// - lut_wdata   out  8  LUT write data
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; retry counter 0; vs_d = ~VS_POL (no false edge after reset).
// - Reset mid-operation: writing stops immediately; the LUT is left partially written; no ack is issued.
// - vs_edge = (rx_vsync==VS_POL) && (vs_d!=VS_POL); vs_d is registered on rx_pclk.
// - IDLE:
//   - cfg_req=1: latch thr<=cfg_thr, retry<=0, busy<=1, go WAIT_VS.
//   - Otherwise stay in IDLE.
// - WAIT_VS:
//   - Stay until vs_edge.
//   - On vs_edge with rx_de=0: addr<=0, go WRITE.
//   - On vs_edge with rx_de=1: ignore the edge and keep waiting.
// - WRITE: runs 256 consecutive cycles.
//   - lut_we=1, lut_addr=0..255 ascending.
//   - lut_wdata = (lut_addr >= thr) ? 8'hFF : 8'h00. Compare is unsigned 8-bit; thr=0 gives all FF.
//   - After the write of addr 255 (no address wrap), go DONE.
//   - rx_de=1 in any WRITE cycle: abort. lut_we drops next cycle; retry<=retry+1.
//     - If retry+1 > MAX_RETRY, go DONE with err.
//     - Otherwise go back to WAIT_VS; the next frame restarts at addr 0.
// - DONE (1 cycle): cfg_ack=1, cfg_err=err, then IDLE with busy<=0 on the following cycle.
// - Handshake:
//   - The requester drops cfg_req in the cycle it sees cfg_ack.
//   - cfg_req and cfg_thr are ignored outside IDLE.
//   - A request still high on re-entry to IDLE starts a new reload.
// - Latency: vs_edge -> first lut_we = 1 cycle. lut_we run = 256 cycles. Last write -> cfg_ack = 1 cycle.
// - Simultaneous events:
//   - vs_edge in DONE/IDLE is not remembered.
//   - rx_de rising in the same cycle as the addr-255 write counts as an abort.
// - All outputs are registered.
// CONFIGURATION
// - LUT_BAND_EN defined:
//   - Adds input cfg_thr_hi[7:0], latched with cfg_thr.
//   - lut_wdata = (addr>=thr && addr<=thr_hi) ? FF : 00.
//   - thr > thr_hi gives all 00.
// - LUT_BAND_EN undefined: no cfg_thr_hi port; single-threshold rule above.
// TESTING
// - T1 reset: assert rst mid-WRITE (addr~100) -> lut_we, cfg_ack, busy go 0 asynchronously; state IDLE.
// - T2 basic reload: cfg_thr=8'h80, vsync pulse with de=0 for 300 cycles
//   -> 256 writes, addr 0..127 data 00, addr 128..255 data FF.
//   -> cfg_ack pulse 1 cycle after the addr-255 write, cfg_err=0.
// - T3 abort/retry: rx_de=1 at write cycle 50 of frame 1, clean blanking in frame 2
//   -> lut_we low from cycle 51; full 0..255 rewrite in frame 2; ack with err=0.
// - T4 give-up: MAX_RETRY=3, de asserted during every write attempt
//   -> 4 aborts, then cfg_ack=1 with cfg_err=1, busy low next cycle.
// - T5 boundaries: cfg_thr=00 -> all FF; cfg_thr=FF -> only addr 255 FF.
//   Request changes while busy -> latched value unchanged.
// - T6 LUT_BAND_EN: thr=40, thr_hi=5F -> FF exactly for addr 0x40..0x5F; thr=90, thr_hi=10 -> all 00.

Source files
------------

// File: rtl/lut_reload_ctrl_if.sv
// Requester and LUT write-port bundle for lut_reload_ctrl.
// Optional macro LUT_BAND_EN adds the upper band threshold cfg_thr_hi.
interface lut_reload_ctrl_if;
    logic       cfg_req;
    logic [7:0] cfg_thr;
`ifdef LUT_BAND_EN
    logic [7:0] cfg_thr_hi;
`endif
    logic       cfg_ack;
    logic       cfg_err;
    logic       busy;
    logic       lut_we;
    logic [7:0] lut_addr;
    logic [7:0] lut_wdata;

`ifdef LUT_BAND_EN
    modport master (
        output cfg_req, cfg_thr, cfg_thr_hi,
        input  cfg_ack, cfg_err, busy, lut_we, lut_addr, lut_wdata
    );
    modport slave (
        input  cfg_req, cfg_thr, cfg_thr_hi,
        output cfg_ack, cfg_err, busy, lut_we, lut_addr, lut_wdata
    );
`else
    modport master (
        output cfg_req, cfg_thr,
        input  cfg_ack, cfg_err, busy, lut_we, lut_addr, lut_wdata
    );
    modport slave (
        input  cfg_req, cfg_thr,
        output cfg_ack, cfg_err, busy, lut_we, lut_addr, lut_wdata
    );
`endif
endinterface

// File: rtl/lut_reload_ctrl.sv
// Reloads the 256x8 binarization LUT during vertical blanking, retrying when active video interrupts a pass.
// Optional macro LUT_BAND_EN switches the table from a single threshold to a [thr, thr_hi] band.
module lut_reload_ctrl #(
    parameter bit VS_POL    = 1'b1,
    parameter int MAX_RETRY = 3
) (
    input  logic             rx_pclk,
    input  logic             rst,
    input  logic             rx_vsync,
    input  logic             rx_de,
    lut_reload_ctrl_if.slave cfg
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        WRITE,
        DONE
    } state_t;

    localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRY);

    state_t     state;
    state_t     state_nxt;
    logic       vs_d;
    logic       vs_edge;
    logic [7:0] thr;
    logic [7:0] thr_nxt;
`ifdef LUT_BAND_EN
    logic [7:0] thr_hi;
    logic [7:0] thr_hi_nxt;
`endif
    logic [3:0] retry;
    logic [3:0] retry_nxt;
    logic [4:0] retry_inc;
    logic       we_q;
    logic       we_nxt;
    logic [7:0] addr_q;
    logic [7:0] addr_nxt;
    logic [7:0] addr_inc;
    logic [7:0] wdata_q;
    logic [7:0] wdata_nxt;
    logic       ack_q;
    logic       ack_nxt;
    logic       err_q;
    logic       err_nxt;
    logic       busy_q;
    logic       busy_nxt;
    logic [7:0] fill_addr;
    logic [7:0] fill_data;

    assign vs_edge   = (rx_vsync == VS_POL) && (vs_d != VS_POL);
    assign retry_inc = {1'b0, retry} + 5'd1;
    assign addr_inc  = addr_q + 8'd1;

    // Address about to be written: 0 when a pass starts, otherwise the next one in the sweep.
    assign fill_addr = (state == WRITE) ? addr_inc : 8'd0;

`ifdef LUT_BAND_EN
    assign fill_data = ((fill_addr >= thr) && (fill_addr <= thr_hi)) ? 8'hFF : 8'h00;
`else
    assign fill_data = (fill_addr >= thr) ? 8'hFF : 8'h00;
`endif

    always_comb begin
        state_nxt  = state;
        thr_nxt    = thr;
`ifdef LUT_BAND_EN
        thr_hi_nxt = thr_hi;
`endif
        retry_nxt  = retry;
        we_nxt     = 1'b0;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        busy_nxt   = busy_q;

        case (state)
            IDLE: begin
                if (cfg.cfg_req) begin
                    thr_nxt    = cfg.cfg_thr;
`ifdef LUT_BAND_EN
                    thr_hi_nxt = cfg.cfg_thr_hi;
`endif
                    retry_nxt  = 4'd0;
                    busy_nxt   = 1'b1;
                    state_nxt  = WAIT_VS;
                end
            end

            WAIT_VS: begin
                if (vs_edge && !rx_de) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = 8'd0;
                    wdata_nxt = fill_data;
                    state_nxt = WRITE;
                end
            end

            // Active video mid-pass means the table is torn; retry next frame or give up.
            WRITE: begin
                if (rx_de) begin
                    retry_nxt = retry_inc[3:0];
                    if (retry_inc > RETRY_LIMIT) begin
                        ack_nxt   = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT_VS;
                    end
                end else if (addr_q == 8'hFF) begin
                    ack_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = addr_inc;
                    wdata_nxt = fill_data;
                end
            end

            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rx_pclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            vs_d    <= ~VS_POL;
            thr     <= 8'd0;
`ifdef LUT_BAND_EN
            thr_hi  <= 8'd0;
`endif
            retry   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            vs_d    <= rx_vsync;
            thr     <= thr_nxt;
`ifdef LUT_BAND_EN
            thr_hi  <= thr_hi_nxt;
`endif
            retry   <= retry_nxt;
            we_q    <= we_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            ack_q   <= ack_nxt;
            err_q   <= err_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign cfg.lut_we    = we_q;
    assign cfg.lut_addr  = addr_q;
    assign cfg.lut_wdata = wdata_q;
    assign cfg.cfg_ack   = ack_q;
    assign cfg.cfg_err   = err_q;
    assign cfg.busy      = busy_q;

endmodule

// File: tb/tb_lut_reload_ctrl.sv
// Scoreboard bench for lut_reload_ctrl: expected LUT writes and acks are queued, a negedge monitor checks them.
// Band-mode vectors run only when LUT_BAND_EN is defined.
module tb_lut_reload_ctrl;

    typedef struct {
        bit         is_ack;
        logic [7:0] addr;
        logic [7:0] data;
        bit         err;
    } exp_t;

    logic rx_pclk;
    logic rst;
    logic rx_vsync;
    logic rx_de;

    lut_reload_ctrl_if cfg();

    lut_reload_ctrl #(
        .VS_POL    (1'b1),
        .MAX_RETRY (3)
    ) dut (
        .rx_pclk  (rx_pclk),
        .rst      (rst),
        .rx_vsync (rx_vsync),
        .rx_de    (rx_de),
        .cfg      (cfg)
    );

    int         checks = 0;
    int         errors = 0;
    int         acks_seen = 0;
    exp_t       sb_q[$];
    exp_t       mon_e;
    logic       prev_we = 1'b0;
    logic [7:0] prev_addr = 8'd0;
    logic [7:0] cur_thr = 8'd0;
`ifdef LUT_BAND_EN
    logic [7:0] cur_thr_hi = 8'hFF;
`endif

    initial rx_pclk = 1'b0;
    always #5 rx_pclk = ~rx_pclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] expData(input int a);
`ifdef LUT_BAND_EN
        return (a >= int'(cur_thr) && a <= int'(cur_thr_hi)) ? 8'hFF : 8'h00;
`else
        return (a >= int'(cur_thr)) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic pushWrites(input int last);
        exp_t e;
        for (int i = 0; i <= last; i++) begin
            e.is_ack = 1'b0;
            e.addr   = 8'(i);
            e.data   = expData(i);
            e.err    = 1'b0;
            sb_q.push_back(e);
        end
    endtask

    task automatic pushAck(input bit err);
        exp_t e;
        e.is_ack = 1'b1;
        e.addr   = 8'd0;
        e.data   = 8'd0;
        e.err    = err;
        sb_q.push_back(e);
    endtask

    task automatic requestReload(input logic [7:0] thr);
        @(posedge rx_pclk); #1;
        cfg.cfg_req = 1'b1;
        cfg.cfg_thr = thr;
        cur_thr     = thr;
        @(posedge rx_pclk); #1;
        checkOutput("busy_on_accept", int'(cfg.busy), 1);
    endtask

    // de_at >= 0: rx_de rises during that write cycle; -1: clean blanking; -2: de already high at the vsync edge.
    task automatic applyStimulus(input int de_at, input int len, input bit chk_lat);
        bit ack_prev;
        ack_prev = 1'b0;
        @(posedge rx_pclk); #1;
        rx_vsync = 1'b1;
        rx_de    = (de_at == -2);
        if (chk_lat) checkOutput("we_before_edge", int'(cfg.lut_we), 0);
        for (int c = 1; c <= len; c++) begin
            @(posedge rx_pclk); #1;
            if (chk_lat && c == 1) checkOutput("vs_to_we_latency", int'(cfg.lut_we), 1);
            if (c == 4) rx_vsync = 1'b0;
            if (de_at >= 0 && c - 1 >= de_at) rx_de = 1'b1;
            if (ack_prev) checkOutput("busy_after_ack", int'(cfg.busy), 0);
            ack_prev = cfg.cfg_ack;
            if (cfg.cfg_ack) begin
                acks_seen++;
                checkOutput("busy_during_ack", int'(cfg.busy), 1);
                cfg.cfg_req = 1'b0;
            end
        end
        rx_de = 1'b0;
    endtask

    always @(negedge rx_pclk) begin
        if (rst) begin
            prev_we   = 1'b0;
            prev_addr = 8'd0;
        end else begin
            if (cfg.lut_we) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0h, expected no write", cfg.lut_addr);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("wr_kind", 0, int'(mon_e.is_ack));
                    checkOutput("wr_addr", int'(cfg.lut_addr), int'(mon_e.addr));
                    checkOutput("wr_data", int'(cfg.lut_wdata), int'(mon_e.data));
                end
            end
            if (cfg.cfg_ack) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_ack: got ack err=%0d, expected no ack", cfg.cfg_err);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("ack_kind", 1, int'(mon_e.is_ack));
                    checkOutput("ack_err", int'(cfg.cfg_err), int'(mon_e.err));
                    checkOutput("ack_latency", int'(prev_we), 1);
                    if (!mon_e.err) checkOutput("ack_after_255", int'(prev_addr), 255);
                end
            end
            prev_we   = cfg.lut_we;
            prev_addr = cfg.lut_addr;
        end
    end

    initial begin
        rst         = 1'b1;
        rx_vsync    = 1'b0;
        rx_de       = 1'b0;
        cfg.cfg_req = 1'b0;
        cfg.cfg_thr = 8'h00;
`ifdef LUT_BAND_EN
        cfg.cfg_thr_hi = 8'hFF;
`endif
        repeat (3) @(posedge rx_pclk);
        #1;
        checkOutput("rst_lut_we", int'(cfg.lut_we), 0);
        checkOutput("rst_lut_addr", int'(cfg.lut_addr), 0);
        checkOutput("rst_lut_wdata", int'(cfg.lut_wdata), 0);
        checkOutput("rst_cfg_ack", int'(cfg.cfg_ack), 0);
        checkOutput("rst_cfg_err", int'(cfg.cfg_err), 0);
        checkOutput("rst_busy", int'(cfg.busy), 0);
        @(negedge rx_pclk);
        rst = 1'b0;

        $display("[TB] basic reload thr=80");
        requestReload(8'h80);
        pushWrites(255);
        pushAck(1'b0);
        applyStimulus(-1, 300, 1'b1);
        checkOutput("basic_ack_count", acks_seen, 1);

        $display("[TB] reset in the middle of a write pass");
        requestReload(8'h80);
        pushWrites(99);
        @(posedge rx_pclk); #1;
        rx_vsync = 1'b1;
        repeat (4) @(posedge rx_pclk);
        #1;
        rx_vsync = 1'b0;
        repeat (97) @(posedge rx_pclk);
        #2;
        rst = 1'b1;
        cfg.cfg_req = 1'b0;
        #1;
        checkOutput("async_rst_lut_we", int'(cfg.lut_we), 0);
        checkOutput("async_rst_lut_addr", int'(cfg.lut_addr), 0);
        checkOutput("async_rst_busy", int'(cfg.busy), 0);
        checkOutput("async_rst_cfg_ack", int'(cfg.cfg_ack), 0);
        @(negedge rx_pclk);
        rst = 1'b0;
        @(posedge rx_pclk); #1;
        checkOutput("idle_after_rst_busy", int'(cfg.busy), 0);
        checkOutput("idle_after_rst_we", int'(cfg.lut_we), 0);
        checkOutput("sb_empty_after_rst", sb_q.size(), 0);
        checkOutput("rst_no_ack", acks_seen, 1);

        $display("[TB] abort at write 50, ignored edge, clean retry");
        requestReload(8'h33);
        pushWrites(50);
        pushWrites(255);
        pushAck(1'b0);
        applyStimulus(50, 300, 1'b0);
        applyStimulus(-2, 300, 1'b0);
        applyStimulus(-1, 300, 1'b0);
        checkOutput("retry_ack_count", acks_seen, 2);

        $display("[TB] give up after four aborts, last one at addr 255");
        requestReload(8'h10);
        pushWrites(10);
        pushWrites(0);
        pushWrites(200);
        pushWrites(255);
        pushAck(1'b1);
        applyStimulus(10, 300, 1'b0);
        applyStimulus(0, 300, 1'b0);
        applyStimulus(200, 300, 1'b0);
        applyStimulus(255, 300, 1'b0);
        checkOutput("giveup_ack_count", acks_seen, 3);

        $display("[TB] threshold boundaries");
        requestReload(8'h00);
        pushWrites(255);
        pushAck(1'b0);
        applyStimulus(-1, 300, 1'b0);
        requestReload(8'hFF);
        cfg.cfg_thr = 8'h00;
        pushWrites(255);
        pushAck(1'b0);
        applyStimulus(-1, 300, 1'b0);
        checkOutput("boundary_ack_count", acks_seen, 5);

`ifdef LUT_BAND_EN
        $display("[TB] band mode");
        cfg.cfg_thr_hi = 8'h5F;
        cur_thr_hi     = 8'h5F;
        requestReload(8'h40);
        pushWrites(255);
        pushAck(1'b0);
        applyStimulus(-1, 300, 1'b0);
        cfg.cfg_thr_hi = 8'h10;
        cur_thr_hi     = 8'h10;
        requestReload(8'h90);
        pushWrites(255);
        pushAck(1'b0);
        applyStimulus(-1, 300, 1'b0);
        checkOutput("band_ack_count", acks_seen, 7);
`endif

        repeat (5) @(posedge rx_pclk);
        #1;
        checkOutput("sb_drained", sb_q.size(), 0);
        checkOutput("final_busy", int'(cfg.busy), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
